// File: rtl/i2c_pkg.sv
// Shared opcode and state definitions for the I2C master.
package i2c_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_START     = 3'd1,
        OP_RESTART   = 3'd2,
        OP_WRITE     = 3'd3,
        OP_READ_ACK  = 3'd4,
        OP_READ_NACK = 3'd5,
        OP_STOP      = 3'd6,
        OP_RSVD      = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RSTART,
        BIT,
        STOP
    } state_e;

    localparam logic [3:0] ACK_SLOT = 4'd8;

    // START needs a free bus; every other bus command needs an owned one.
    function automatic logic cmd_legal(input logic [2:0] op, input logic owned);
        case (op)
            OP_NOP:   return 1'b1;
            OP_START: return !owned;
            OP_RESTART, OP_WRITE, OP_READ_ACK, OP_READ_NACK, OP_STOP: return owned;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period timer with a stretch stall and a stretch timeout counter.
module i2c_tick_gen #(
    parameter int unsigned CLK_DIV     = 64,
    parameter int unsigned STRETCH_TMO = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic stall,
    output logic quarter_done,
    output logic tmo
);

    localparam int unsigned QW = $clog2(CLK_DIV);
    localparam int unsigned SW = $clog2(STRETCH_TMO + 1);
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(STRETCH_TMO - 1);

    logic [QW-1:0] qcnt;
    logic [SW-1:0] scnt;

    assign quarter_done = run && !stall && (qcnt == Q_LAST);
    assign tmo          = run && stall && (scnt == S_LAST);

    // The quarter count freezes while stalled; the stretch count only runs then.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            qcnt <= '0;
            scnt <= '0;
        end else if (stall) begin
            scnt <= scnt + SW'(1);
        end else begin
            scnt <= '0;
            qcnt <= quarter_done ? '0 : qcnt + QW'(1);
        end
    end

endmodule

// File: rtl/i2c_master_gen.sv
// Byte-command I2C master: START/RESTART/WRITE/READ/STOP over open-drain SDAT/SCLK.
module i2c_master_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 64,
    parameter bit          STRETCH_EN  = 1'b1,
    parameter int unsigned STRETCH_TMO = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    inout  wire        SDAT,
    inout  wire        SCLK,
    input  logic       CMD_VALID,
    input  logic [2:0] CMD_OP,
    input  logic [7:0] CMD_DATA,
    output logic       CMD_READY,
    output logic       BUSY,
    output logic [7:0] RD_DATA,
    output logic       RD_VALID,
    output logic       ACK_ERR,
    output logic       CMD_ERR,
    output logic       TIMEOUT
);

    state_e      state;
    op_e         op;
    logic [1:0]  quarter;
    logic [3:0]  bit_idx;
    logic [7:0]  shift;
    logic        ack;
    logic        owned;
    logic        sda_low;
    logic        scl_low;
    logic        sda_in;
    logic        scl_in;
    logic        stall;
    logic        quarter_done;
    logic        tmo;
    logic        accept;

    assign SDAT   = sda_low ? 1'b0 : 1'bz;
    assign SCLK   = scl_low ? 1'b0 : 1'bz;
    assign sda_in = SDAT;
    assign scl_in = SCLK;

    assign CMD_READY = !BUSY && !TIMEOUT;
    assign accept    = CMD_VALID && CMD_READY;

    // Stretching is only honoured in the phases where the master has just released SCLK.
    assign stall = STRETCH_EN && !scl_in &&
                   ((state == BIT && quarter == 2'd2) || (state == STOP && quarter == 2'd1));

    i2c_tick_gen #(
        .CLK_DIV     (CLK_DIV),
        .STRETCH_TMO (STRETCH_TMO)
    ) u_tick (
        .clk          (CLK),
        .rst          (RST),
        .run          (state != IDLE),
        .stall        (stall),
        .quarter_done (quarter_done),
        .tmo          (tmo)
    );

    always_ff @(posedge CLK) begin
        RD_VALID <= 1'b0;
        CMD_ERR  <= 1'b0;
        if (RST) begin
            state   <= IDLE;
            op      <= OP_NOP;
            quarter <= '0;
            bit_idx <= '0;
            shift   <= '0;
            ack     <= 1'b0;
            owned   <= 1'b0;
            sda_low <= 1'b0;
            scl_low <= 1'b0;
            BUSY    <= 1'b0;
            RD_DATA <= '0;
            ACK_ERR <= 1'b0;
            TIMEOUT <= 1'b0;
        end else if (tmo) begin
            state   <= IDLE;
            BUSY    <= 1'b0;
            TIMEOUT <= 1'b1;
            owned   <= 1'b0;
            sda_low <= 1'b0;
            scl_low <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op      <= op_e'(CMD_OP);
                    quarter <= '0;
                    bit_idx <= '0;
                    shift   <= CMD_DATA;
                    if (!cmd_legal(CMD_OP, owned)) begin
                        CMD_ERR <= 1'b1;
                    end else begin
                        case (op_e'(CMD_OP))
                            OP_START: begin
                                state   <= START;
                                BUSY    <= 1'b1;
                                ACK_ERR <= 1'b0;
                                sda_low <= 1'b0;
                                scl_low <= 1'b0;
                            end
                            OP_RESTART: begin
                                state   <= RSTART;
                                BUSY    <= 1'b1;
                                sda_low <= 1'b0;
                            end
                            OP_WRITE: begin
                                state   <= BIT;
                                BUSY    <= 1'b1;
                                sda_low <= !CMD_DATA[7];
                            end
                            OP_READ_ACK, OP_READ_NACK: begin
                                state   <= BIT;
                                BUSY    <= 1'b1;
                                sda_low <= 1'b0;
                            end
                            OP_STOP: begin
                                state   <= STOP;
                                BUSY    <= 1'b1;
                                sda_low <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                // RESTART enters with SCLK low: SDAT is freed in Q0, SCLK in Q1.
                START, RSTART: if (quarter_done) begin
                    quarter <= quarter + 2'd1;
                    case (quarter)
                        2'd0: if (state == RSTART) scl_low <= 1'b0;
                        2'd1: sda_low <= 1'b1;
                        2'd2: scl_low <= 1'b1;
                        default: begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                            owned <= 1'b1;
                        end
                    endcase
                end

                BIT: if (quarter_done) begin
                    quarter <= quarter + 2'd1;
                    case (quarter)
                        2'd1: scl_low <= 1'b0;
                        2'd2: begin
                            if (bit_idx == ACK_SLOT) ack <= sda_in;
                            else shift <= {shift[6:0], sda_in};
                        end
                        2'd3: begin
                            scl_low <= 1'b1;
                            if (bit_idx == ACK_SLOT) begin
                                state <= IDLE;
                                BUSY  <= 1'b0;
                                if (op == OP_WRITE) begin
                                    ACK_ERR <= ACK_ERR | ack;
                                end else begin
                                    RD_DATA  <= shift;
                                    RD_VALID <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                                if (bit_idx == 4'd7) sda_low <= (op == OP_READ_ACK);
                                else sda_low <= (op == OP_WRITE) && !shift[7];
                            end
                        end
                        default: ;
                    endcase
                end

                STOP: if (quarter_done) begin
                    quarter <= quarter + 2'd1;
                    case (quarter)
                        2'd0: scl_low <= 1'b0;
                        2'd2: sda_low <= 1'b0;
                        2'd3: begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                            owned <= 1'b0;
                        end
                        default: ;
                    endcase
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_gen.sv
// Self-checking bench: a per-cycle waveform model of the I2C command stream drives a scripted slave and checks the DUT.
module tb_i2c_master_gen;

    localparam int unsigned D   = 4;
    localparam int unsigned TMO = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, busy, rd_valid, ack_err, cmd_err, timeout;
    logic [7:0] rd_data;
    wire        sdat;
    wire        sclk;
    logic       slv_sda_low = 1'b0;
    logic       slv_scl_low = 1'b0;

    pullup (sdat);
    pullup (sclk);
    assign sdat = slv_sda_low ? 1'b0 : 1'bz;
    assign sclk = slv_scl_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master_gen #(
        .CLK_DIV     (D),
        .STRETCH_EN  (1'b1),
        .STRETCH_TMO (TMO)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .SDAT      (sdat),
        .SCLK      (sclk),
        .CMD_VALID (cmd_valid),
        .CMD_OP    (cmd_op),
        .CMD_DATA  (cmd_data),
        .CMD_READY (cmd_ready),
        .BUSY      (busy),
        .RD_DATA   (rd_data),
        .RD_VALID  (rd_valid),
        .ACK_ERR   (ack_err),
        .CMD_ERR   (cmd_err),
        .TIMEOUT   (timeout)
    );

    // One entry per clock cycle: master line levels (1 = released), slave pull-downs, flags.
    typedef struct {
        bit       busy;
        bit       m_scl;
        bit       m_sda;
        bit       s_scl;
        bit       s_sda;
        bit       err;
        bit       rdv;
        bit [7:0] rdd;
        bit       aerr;
        bit       tmo;
    } ent_t;

    ent_t q[$];
    bit   owned_m = 1'b0;
    bit   sda_m   = 1'b1;
    bit   aerr_m  = 1'b0;
    bit   tmo_m   = 1'b0;
    bit   checking = 1'b0;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic        prev_scl = 1'b1;
    logic        prev_busy = 1'b0;
    int unsigned blen = 0, last_len = 0, err_cnt = 0, rise_cnt = 0;
    logic [15:0] rise_bits = '0;
    logic [7:0]  rd_log[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit b, input bit mscl, input bit msda, input bit sscl, input bit ssda,
                        input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            q.push_back('{b, mscl, msda, sscl, ssda, 1'b0, 1'b0, 8'h00, aerr_m, tmo_m});
    endtask

    task automatic tail(input bit err, input bit rdv, input bit [7:0] rdd);
        q.push_back('{1'b0, !owned_m, sda_m, 1'b0, 1'b0, err, rdv, rdd, aerr_m, tmo_m});
    endtask

    // Waveform of one accepted command; sbit/sn = bit index and length of a slave SCLK hold.
    task automatic model_cmd(input logic [2:0] op, input logic [7:0] data, input logic [7:0] sbyte,
                             input bit sack, input int sbit, input int unsigned sn);
        bit legal, v, s, lvl, ackb;
        bit [7:0] rb;
        legal = (op == 3'd0) || (op == 3'd1 && !owned_m) || (op >= 3'd2 && op <= 3'd6 && owned_m);
        rb = '0; ackb = 1'b0; v = 1'b1; s = 1'b0;
        if (!legal) begin
            tail(1'b1, 1'b0, 8'h00);
            return;
        end
        case (op)
            3'd1: begin
                aerr_m = 1'b0;
                push(1, 1, 1, 0, 0, 2*D); push(1, 1, 0, 0, 0, D); push(1, 0, 0, 0, 0, D);
                owned_m = 1'b1; sda_m = 1'b0;
            end
            3'd2: begin
                push(1, 0, 1, 0, 0, D); push(1, 1, 1, 0, 0, D);
                push(1, 1, 0, 0, 0, D); push(1, 0, 0, 0, 0, D);
                sda_m = 1'b0;
            end
            3'd3, 3'd4, 3'd5: begin
                for (int b = 0; b < 9; b++) begin
                    if (b < 8) begin
                        v = (op == 3'd3) ? data[7-b] : 1'b1;
                        s = (op == 3'd3) ? 1'b0 : !sbyte[7-b];
                    end else begin
                        v = (op != 3'd4);
                        s = (op == 3'd3) && sack;
                    end
                    push(1, 0, v, 0, s, 2*D);
                    if (b == sbit && sn >= TMO) begin
                        push(1, 1, v, 1, s, TMO);
                        tmo_m = 1'b1; owned_m = 1'b0; sda_m = 1'b1;
                        tail(1'b0, 1'b0, 8'h00);
                        return;
                    end
                    if (b == sbit) push(1, 1, v, 1, s, sn);
                    push(1, 1, v, 0, s, 2*D);
                    lvl = v & !s;
                    if (b < 8) rb = {rb[6:0], lvl};
                    else ackb = lvl;
                end
                sda_m = v;
                if (op == 3'd3) begin
                    aerr_m = aerr_m | ackb;
                    tail(1'b0, 1'b0, 8'h00);
                end else begin
                    tail(1'b0, 1'b1, rb);
                end
                return;
            end
            3'd6: begin
                push(1, 0, 0, 0, 0, D); push(1, 1, 0, 0, 0, 2*D); push(1, 1, 1, 0, 0, D);
                owned_m = 1'b0; sda_m = 1'b1;
            end
            default: ;
        endcase
        tail(1'b0, 1'b0, 8'h00);
    endtask

    // Scripted slave follows the model entry of the current cycle.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            slv_scl_low = q[0].s_scl;
            slv_sda_low = q[0].s_sda;
        end else begin
            slv_scl_low = 1'b0;
            slv_sda_low = 1'b0;
        end
    end

    // Single compare process plus a small monitor feeding the literal checks.
    always @(negedge clk) begin
        ent_t e;
        if (checking) begin
            if (q.size() > 0) e = q.pop_front();
            else e = '{1'b0, !owned_m, sda_m, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, aerr_m, tmo_m};
            chk("busy", 16'(busy), 16'(e.busy));
            chk("sclk", 16'(sclk), 16'(e.m_scl & !e.s_scl));
            chk("sdat", 16'(sdat), 16'(e.m_sda & !e.s_sda));
            chk("cmd_err", 16'(cmd_err), 16'(e.err));
            chk("rd_valid", 16'(rd_valid), 16'(e.rdv));
            if (e.rdv) chk("rd_data", 16'(rd_data), 16'(e.rdd));
            chk("ack_err", 16'(ack_err), 16'(e.aerr));
            chk("timeout", 16'(timeout), 16'(e.tmo));
            chk("cmd_ready", 16'(cmd_ready), 16'(!e.busy && !e.tmo));
        end
        if (sclk === 1'b1 && prev_scl === 1'b0) begin
            rise_bits = {rise_bits[14:0], sdat};
            rise_cnt++;
        end
        if (busy === 1'b1) blen++;
        else if (prev_busy === 1'b1) begin
            last_len = blen;
            blen = 0;
        end
        if (cmd_err === 1'b1) err_cnt++;
        if (rd_valid === 1'b1) rd_log.push_back(rd_data);
        prev_scl = sclk;
        prev_busy = busy;
    end

    task automatic cmd(input logic [2:0] op, input logic [7:0] data, input logic [7:0] sbyte,
                       input bit sack, input int sbit, input int unsigned sn);
        int unsigned n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("cmd_ready_wait", 16'(cmd_ready), 16'd1);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        @(posedge clk);
        model_cmd(op, data, sbyte, sack, sbit, sn);
        #1;
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        @(posedge clk); #2;
        while (q.size() != 0 && n < 20000) begin
            @(posedge clk); #2;
            n++;
        end
        chk("idle_wait", 16'(q.size()), 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        q.delete();
        owned_m = 1'b0; sda_m = 1'b1; aerr_m = 1'b0; tmo_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
    endtask

    int unsigned err0, rise0;

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1 checking = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("rst_ready", 16'(cmd_ready), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_rd_data", 16'(rd_data), 16'h00);
        chk("rst_lines", 16'({sclk, sdat}), 16'b11);

        // WRITE 0xA5 with slave ACK
        cmd(3'd1, 8'h00, 8'h00, 0, -1, 0);
        cmd(3'd3, 8'hA5, 8'h00, 1, -1, 0);
        wait_idle();
        chk("a5_bits", 16'(rise_bits[8:0]), 16'h14A);
        chk("a5_busy_len", 16'(last_len), 16'd144);
        chk("a5_ack_err", 16'(ack_err), 16'd0);
        cmd(3'd6, 8'h00, 8'h00, 0, -1, 0);
        wait_idle();
        chk("stop_lines", 16'({sclk, sdat}), 16'b11);

        // WRITE 0x3C with slave NACK, then a fresh START clears ACK_ERR
        cmd(3'd1, 8'h00, 8'h00, 0, -1, 0);
        cmd(3'd3, 8'h3C, 8'h00, 0, -1, 0);
        wait_idle();
        chk("nack_ack_err", 16'(ack_err), 16'd1);
        cmd(3'd6, 8'h00, 8'h00, 0, -1, 0);
        cmd(3'd1, 8'h00, 8'h00, 0, -1, 0);
        wait_idle();
        chk("start_clears_ack_err", 16'(ack_err), 16'd0);

        // READ_ACK 0x5A, READ_NACK 0xC3
        rd_log.delete();
        cmd(3'd4, 8'h00, 8'h5A, 0, -1, 0);
        wait_idle();
        chk("read_ack_sdat", 16'(sdat), 16'd0);
        cmd(3'd5, 8'h00, 8'hC3, 0, -1, 0);
        wait_idle();
        chk("read_nack_sdat", 16'(sdat), 16'd1);
        cmd(3'd6, 8'h00, 8'h00, 0, -1, 0);
        wait_idle();
        chk("rd_count", 16'(rd_log.size()), 16'd2);
        if (rd_log.size() == 2) begin
            chk("rd_first", 16'(rd_log[0]), 16'h5A);
            chk("rd_second", 16'(rd_log[1]), 16'hC3);
        end

        // 50-cycle stretch in bit 3 of WRITE 0xFF
        cmd(3'd1, 8'h00, 8'h00, 0, -1, 0);
        cmd(3'd3, 8'hFF, 8'h00, 1, 3, 50);
        wait_idle();
        chk("stretch_busy_len", 16'(last_len), 16'd194);
        chk("stretch_timeout", 16'(timeout), 16'd0);
        cmd(3'd6, 8'h00, 8'h00, 0, -1, 0);
        wait_idle();

        // Illegal commands
        err0 = err_cnt;
        rise0 = rise_cnt;
        cmd(3'd3, 8'h55, 8'h00, 0, -1, 0);
        cmd(3'd6, 8'h00, 8'h00, 0, -1, 0);
        cmd(3'd1, 8'h00, 8'h00, 0, -1, 0);
        cmd(3'd1, 8'h00, 8'h00, 0, -1, 0);
        wait_idle();
        chk("cmd_err_count", 16'(err_cnt - err0), 16'd3);
        chk("no_scl_rise", 16'(rise_cnt - rise0), 16'd0);
        cmd(3'd7, 8'h00, 8'h00, 0, -1, 0);
        cmd(3'd0, 8'h00, 8'h00, 0, -1, 0);
        cmd(3'd6, 8'h00, 8'h00, 0, -1, 0);
        wait_idle();

        // Reset in bit 4 of WRITE 0x81
        cmd(3'd1, 8'h00, 8'h00, 0, -1, 0);
        wait_idle();
        cmd(3'd3, 8'h81, 8'h00, 0, -1, 0);
        repeat (16*D + 6) @(posedge clk);
        do_reset();
        chk("mid_rst_busy", 16'(busy), 16'd0);
        chk("mid_rst_ready", 16'(cmd_ready), 16'd1);
        chk("mid_rst_lines", 16'({sclk, sdat}), 16'b11);
        cmd(3'd1, 8'h00, 8'h00, 0, -1, 0);
        wait_idle();
        chk("fresh_start_scl", 16'(sclk), 16'd0);

        // Stretch longer than the timeout
        cmd(3'd3, 8'hFF, 8'h00, 1, 3, 5000);
        wait_idle();
        chk("tmo_flag", 16'(timeout), 16'd1);
        chk("tmo_ready", 16'(cmd_ready), 16'd0);
        chk("tmo_lines", 16'({sclk, sdat}), 16'b11);
        repeat (10) @(posedge clk);
        do_reset();
        chk("tmo_cleared", 16'(timeout), 16'd0);
        chk("tmo_ready_back", 16'(cmd_ready), 16'd1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
